// File: rtl/nova_trace_if.sv
// Bus bundle for the Nova instruction trace recorder: capture/control inputs and readback/status outputs.
interface nova_trace_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int PC_WIDTH   = 15,
  parameter int INST_WIDTH = 16
);
  logic                           oe;
  logic [INST_WIDTH-1:0]          inst;
  logic [PC_WIDTH-1:0]            pc;
  logic                           arm;
  logic                           stop;
  logic [1:0]                     filter;
  logic                           trig_en;
  logic [PC_WIDTH-1:0]            trig_pc;
  logic [DEPTH_LOG2-1:0]          post_cnt;
  logic                           rd_en;
  logic [DEPTH_LOG2-1:0]          rd_idx;
  logic [PC_WIDTH+INST_WIDTH-1:0] rd_data;
  logic                           rd_valid;
  logic [1:0]                     state;
  logic [DEPTH_LOG2:0]            count;
  logic                           triggered;
  logic                           done;

  modport master (
    output oe, inst, pc, arm, stop, filter, trig_en, trig_pc, post_cnt, rd_en, rd_idx,
    input  rd_data, rd_valid, state, count, triggered, done
  );

  modport slave (
    input  oe, inst, pc, arm, stop, filter, trig_en, trig_pc, post_cnt, rd_en, rd_idx,
    output rd_data, rd_valid, state, count, triggered, done
  );
endinterface

// File: rtl/nova_trace.sv
// Circular {pc, inst} trace buffer with class filter, PC-match trigger plus post-trigger
// count, and indexed readback (index 0 = oldest valid entry) once capture has stopped.
module nova_trace #(
  parameter int DEPTH_LOG2 = 6,
  parameter int PC_WIDTH   = 15,
  parameter int INST_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  nova_trace_if.slave  bus
);

  localparam int DW = PC_WIDTH + INST_WIDTH;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2-1:0] r_remaining;
  logic                  r_triggered;
  logic                  r_rd_valid;
  logic [DW-1:0]         r_rd_data;
  logic [DW-1:0]         r_mem [1<<DEPTH_LOG2];

  logic                  w_filt_hit, w_qual, w_pc_hit, w_trig_hit;
  logic                  w_active, w_wr, w_dec_rem;
  logic [DEPTH_LOG2-1:0] w_base, w_raddr;
  logic                  w_rd_ok;

  // Class decode; instruction bit 0 is the MSB, so bits 0..2 are inst[15:13].
  always_comb begin
    w_filt_hit = 1'b0;
    case (bus.filter)
      2'b00: w_filt_hit = 1'b1;
      2'b01: w_filt_hit = (bus.inst[INST_WIDTH-1 -: 3] == 3'b000);
      2'b10: w_filt_hit = (bus.inst[INST_WIDTH-1 -: 3] == 3'b011);
      default: w_filt_hit = bus.inst[INST_WIDTH-1] & (bus.inst[2:0] != 3'b000);
    endcase
  end

  assign w_qual     = bus.oe & w_filt_hit;
  assign w_pc_hit   = bus.trig_en & bus.oe & (bus.pc == bus.trig_pc);
  assign w_active   = (r_state == S_CAPTURE) || (r_state == S_POST);
  assign w_trig_hit = ~bus.arm & (r_state == S_CAPTURE) & w_pc_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; stop wins over the trigger's POST transition
  always_comb begin
    w_state_nxt = r_state;
    if (bus.arm) begin
      w_state_nxt = S_CAPTURE;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          if (bus.stop)      w_state_nxt = S_DONE;
          else if (w_pc_hit) w_state_nxt = (bus.post_cnt == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (bus.stop)                                 w_state_nxt = S_DONE;
          else if (w_qual && (r_remaining == PTR_ONE))  w_state_nxt = S_DONE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output decode: the trigger entry is stored even if the filter rejects it
  always_comb begin
    w_wr      = ~bus.arm & w_active & (w_qual | w_trig_hit);
    w_dec_rem = ~bus.arm & (r_state == S_POST) & w_qual;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_triggered <= 1'b0;
    end else if (bus.arm) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_triggered <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (r_count != DEPTH_C) r_count <= r_count + CNT_ONE;
      end
      if (w_trig_hit) begin
        r_triggered <= 1'b1;
        r_remaining <= bus.post_cnt;
      end else if (w_dec_rem) begin
        r_remaining <= r_remaining - PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {bus.pc, bus.inst};
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer
  assign w_base  = (r_count == DEPTH_C) ? r_wr_ptr : '0;
  assign w_raddr = w_base + bus.rd_idx;
  assign w_rd_ok = bus.rd_en & ~w_active & ({1'b0, bus.rd_idx} < r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_rd_data  <= w_rd_ok ? r_mem[w_raddr] : '0;
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.state     = r_state;
  assign bus.count     = r_count;
  assign bus.triggered = r_triggered;
  assign bus.done      = (r_state == S_DONE);

endmodule
